// File: rtl/shuma_pkg.sv
// shuma_pkg: shared constants for the seven-segment scan driver (active-low segment encodings).
package shuma_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;
    localparam logic [7:0] SEG_A = 8'h88;
    localparam logic [7:0] SEG_B = 8'h83;
    localparam logic [7:0] SEG_C = 8'hC6;
    localparam logic [7:0] SEG_D = 8'hA1;
    localparam logic [7:0] SEG_E = 8'h86;
    localparam logic [7:0] SEG_F = 8'h8E;

    localparam logic [15:0][7:0] SEG_TABLE = {
        SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
        SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
    };

    typedef logic [$clog2(NUM_DIGITS)-1:0] digit_t;

endpackage

// File: rtl/shuma_display_if.sv
// shuma_display_if: value-in / digit-select and segment-out bundle of the scan driver.
interface shuma_display_if;
    import shuma_pkg::*;

    logic [31:0]           din;
    logic [NUM_DIGITS-1:0] sel;
    logic [7:0]            seg;

    modport master (output din, input sel, seg);
    modport slave  (input din, output sel, seg);

endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: combinational hex nibble to active-low seven-segment pattern, dp always off.
module seg7_decode
    import shuma_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/shuma_display.sv
// shuma_display: eight-digit multiplexed seven-segment driver; define SHUMA_LZ_BLANK_EN for leading-zero blanking.
module shuma_display
    import shuma_pkg::*;
#(
    parameter int SCAN_CNT = 50000
)
(
    input  logic            clk,
    input  logic            rst_n,
    shuma_display_if.slave  bus
);

    localparam int CW = $clog2(SCAN_CNT);

    logic [CW-1:0]         cnt;
    digit_t                idx;
    logic [31:0]           din_q;
    logic [NUM_DIGITS-1:0] sel_q;
    logic [7:0]            seg_q;
    logic [7:0]            dec;
    logic [7:0]            seg_nxt;
    logic                  wrap;
    logic                  blank;

    assign wrap = cnt == CW'(SCAN_CNT - 1);

    seg7_decode u_dec (
        .nibble (din_q[4*idx +: 4]),
        .seg    (dec)
    );

`ifdef SHUMA_LZ_BLANK_EN
    assign blank = (idx != '0) && ((din_q >> (4*idx)) == '0);
`else
    assign blank = 1'b0;
`endif

    // Blanked digits show nothing; otherwise the decoded nibble of the latched frame.
    always_comb begin
        seg_nxt = blank ? SEG_BLANK : dec;
    end

    // Scan timing, frame latch at the last cycle of digit 7, and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            idx   <= '0;
            din_q <= '0;
            sel_q <= '1;
            seg_q <= SEG_BLANK;
        end else begin
            cnt   <= wrap ? '0 : cnt + 1'b1;
            if (wrap) idx <= idx + 1'b1;
            if (wrap && idx == digit_t'(NUM_DIGITS - 1)) din_q <= bus.din;
            sel_q <= ~(NUM_DIGITS'(1) << idx);
            seg_q <= seg_nxt;
        end
    end

    assign bus.sel = sel_q;
    assign bus.seg = seg_q;

endmodule

// File: tb/tb_shuma_display.sv
// tb_shuma_display: directed self-checking bench for shuma_display with SCAN_CNT=4.
module tb_shuma_display;

    localparam int SCAN = 4;

`ifdef SHUMA_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    localparam logic [7:0] TB_SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };
    localparam logic [7:0] HEX_EXP [8] = '{
        8'h90, 8'hC0, 8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88
    };

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   n      = 0;

    always #10 clk = ~clk;

    shuma_display_if bus ();

    shuma_display #(.SCAN_CNT(SCAN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic test_reset;
        bus.din = '0;
        #2 rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.sel !== 8'hFF || bus.seg !== 8'hFF) begin
                errors++;
                $display("FAIL reset_hold sel=%h seg=%h expected sel=ff seg=ff", bus.sel, bus.seg);
            end
        end
        rst_n = 1'b1;
        n = 0;
        tick();
        checks++;
        if (bus.sel !== 8'hFE || bus.seg !== 8'hC0) begin
            errors++;
            $display("FAIL reset_first_edge sel=%h seg=%h expected sel=fe seg=c0", bus.sel, bus.seg);
        end
    endtask

    task automatic test_scan_zero;
        logic [7:0] es;
        while (n < 16) begin
            tick();
            es = ~(8'b1 << (((n - 1) / SCAN) % 8));
            checks++;
            if (bus.sel !== es || bus.seg !== 8'hC0) begin
                errors++;
                $display("FAIL scan_zero n=%0d sel=%h seg=%h expected sel=%h seg=c0", n, bus.sel, bus.seg, es);
            end
        end
    endtask

    task automatic test_frame_latch;
        logic [7:0]  es;
        logic [7:0]  eg;
        logic [31:0] v;
        int          d;
        v = 32'h12345678;
        bus.din = v;
        while (n < 32) begin
            tick();
            es = ~(8'b1 << (((n - 1) / SCAN) % 8));
            checks++;
            if (bus.sel !== es || bus.seg !== 8'hC0) begin
                errors++;
                $display("FAIL no_tear n=%0d sel=%h seg=%h expected sel=%h seg=c0", n, bus.sel, bus.seg, es);
            end
        end
        while (n < 64) begin
            tick();
            if (n == 40) bus.din = 32'hABCDEF09;
            d  = ((n - 1) / SCAN) % 8;
            es = ~(8'b1 << d);
            eg = TB_SEG[v[4*d +: 4]];
            checks++;
            if (bus.sel !== es || bus.seg !== eg) begin
                errors++;
                $display("FAIL frame2 n=%0d sel=%h seg=%h expected sel=%h seg=%h", n, bus.sel, bus.seg, es, eg);
            end
        end
    endtask

    task automatic test_hex;
        logic [7:0] es;
        int         d;
        while (n < 96) begin
            tick();
            if (n == 95) bus.din = 32'h0000000F;
            d  = ((n - 1) / SCAN) % 8;
            es = ~(8'b1 << d);
            checks++;
            if (bus.sel !== es || bus.seg !== HEX_EXP[d]) begin
                errors++;
                $display("FAIL hex n=%0d sel=%h seg=%h expected sel=%h seg=%h", n, bus.sel, bus.seg, es, HEX_EXP[d]);
            end
        end
    endtask

    task automatic test_boundary_capture;
        logic [7:0] es;
        logic [7:0] eg;
        int         d;
        while (n < 128) begin
            tick();
            if (n == 97) bus.din = 32'h76543210;
            if (n == 127) bus.din = 32'h00000012;
            d  = ((n - 1) / SCAN) % 8;
            es = ~(8'b1 << d);
            eg = (d == 0) ? 8'h8E : (LZ ? 8'hFF : 8'hC0);
            checks++;
            if (bus.sel !== es || bus.seg !== eg) begin
                errors++;
                $display("FAIL boundary n=%0d sel=%h seg=%h expected sel=%h seg=%h", n, bus.sel, bus.seg, es, eg);
            end
        end
    endtask

    task automatic test_lz_blank;
        logic [7:0] es;
        logic [7:0] eg;
        int         d;
        while (n < 160) begin
            tick();
            if (n == 159) bus.din = 32'h00000000;
            d  = ((n - 1) / SCAN) % 8;
            es = ~(8'b1 << d);
            eg = (d == 0) ? 8'hA4 : (d == 1) ? 8'hF9 : (LZ ? 8'hFF : 8'hC0);
            checks++;
            if (bus.sel !== es || bus.seg !== eg) begin
                errors++;
                $display("FAIL lz_12 n=%0d sel=%h seg=%h expected sel=%h seg=%h", n, bus.sel, bus.seg, es, eg);
            end
        end
        while (n < 192) begin
            tick();
            d  = ((n - 1) / SCAN) % 8;
            es = ~(8'b1 << d);
            eg = (d == 0) ? 8'hC0 : (LZ ? 8'hFF : 8'hC0);
            checks++;
            if (bus.sel !== es || bus.seg !== eg) begin
                errors++;
                $display("FAIL lz_0 n=%0d sel=%h seg=%h expected sel=%h seg=%h", n, bus.sel, bus.seg, es, eg);
            end
        end
    endtask

    task automatic test_async_reset;
        logic [7:0] es;
        tick();
        tick();
        bus.din = 32'h12345678;
        #5 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.sel !== 8'hFF || bus.seg !== 8'hFF) begin
            errors++;
            $display("FAIL async_reset_immediate sel=%h seg=%h expected sel=ff seg=ff", bus.sel, bus.seg);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.sel !== 8'hFF || bus.seg !== 8'hFF) begin
            errors++;
            $display("FAIL async_reset_hold sel=%h seg=%h expected sel=ff seg=ff", bus.sel, bus.seg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (n < 12) begin
            tick();
            es = ~(8'b1 << (((n - 1) / SCAN) % 8));
            checks++;
            if (bus.sel !== es || bus.seg !== 8'hC0) begin
                errors++;
                $display("FAIL async_restart n=%0d sel=%h seg=%h expected sel=%h seg=c0", n, bus.sel, bus.seg, es);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_zero();
        test_frame_latch();
        test_hex();
        test_boundary_capture();
        test_lz_blank();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shuma_display.md
# shuma_display

Eight-digit multiplexed seven-segment display driver. Takes a 32-bit value as eight hexadecimal nibbles and scans them onto a shared common-anode segment bus, one digit at a time, with active-low digit selects. Sits at the board-I/O edge, fed by any 32-bit status or counter register in the clock domain.

## Interface
- SCAN_CNT, 50000: clock cycles each digit stays lit (1 ms at 50 MHz); legal range 2..2^20.
- clk  in  1  system clock (50 MHz nominal).
- rst_n  in  1  asynchronous, active-low reset.
- din  in  32  value to display; nibble k (din[4k+3:4k]) drives digit k; digit 0 is rightmost.
- sel  out  8  digit enables, active-low one-hot; sel[k]=0 lights digit k.
- seg  out  8  segments, active-low; seg[0]=a, seg[1]=b … seg[6]=g, seg[7]=dp.

## Operation
- Registers:
  - cnt: 0..SCAN_CNT-1.
  - idx: 3-bit digit index.
  - din_q: 32-bit frame latch.
  - sel and seg: output registers.
- Scan counter:
  - cnt increments every cycle.
  - At cnt==SCAN_CNT-1, cnt returns to 0 and idx increments, wrapping from 7 to 0.
- Frame latch:
  - din_q loads din only on the cycle where cnt==SCAN_CNT-1 and idx==7 (the frame boundary).
  - Between boundaries, din changes have no effect, so no tearing within a frame.
- Outputs, registered every cycle:
  - sel <= ~(8'b1 << idx).
  - seg <= decode(din_q[4·idx+3 : 4·idx]).
- Decode (active-low, dp off): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
- Only one sel bit is ever low. The dp segment is never lit.

## Timing
- Reset (asynchronous assert, synchronous-to-clk release):
  - cnt=0, idx=0, din_q=0.
  - sel=8'hFF (all digits off), seg=8'hFF (all segments off).
- First rising edge after reset release: sel=8'hFE, seg=8'hC0.
- Output latency: one cycle from the idx/din_q state to sel/seg.
- Each digit is lit for exactly SCAN_CNT consecutive cycles. A full frame is 8·SCAN_CNT cycles.
- A din sampled at a frame boundary appears on digit 0 one cycle after the boundary edge.
- Reset asserted mid-scan: outputs go to FF immediately, with no wait for a clock edge.
- din changing in the same cycle as the frame boundary: the value present at that edge is captured.

## Configuration
- SHUMA_LZ_BLANK_EN defined:
  - Leading-zero blanking is enabled.
  - Any digit k>0 for which din_q[31:4k] is all zero drives seg=8'hFF while selected.
  - Digit 0 is never blanked.
  - sel scanning is unchanged.
- Undefined: all eight digits are always decoded, including leading zeros.

## Structure
- Package shuma_pkg holds:
  - the 16 segment encodings as constants;
  - SEG_BLANK=8'hFF;
  - NUM_DIGITS=8.
- Sub-module seg7_decode is purely combinational: 4-bit nibble in, 8-bit active-low pattern out.
- Scan counter, index, frame latch and output registers live in the top.

## Test plan
Run the bench with SCAN_CNT=4 and a 20 ns clock.
- Reset: hold rst_n=0 for 3 cycles -> sel=FF and seg=FF throughout; first edge after release gives sel=FE, seg=C0.
- din=0 -> sel cycles FE, FD, FB, F7, EF, DF, BF, 7F, each held 4 cycles, with seg=C0 on every digit (macro undefined).
- din=32'h12345678 applied before the first frame boundary -> no change during frame 1; from frame 2:
  - sel=FE gives seg=80 ("8");
  - sel=FD gives 8'hF8 ("7");
  - sel=7F gives F9 ("1").
- din=32'hABCDEF09 -> digits 0..7 show 90, C0, 8E, 86, A1, C6, 83, 88.
- Asynchronous reset asserted mid-digit -> sel/seg are FF before the next edge; after release, scanning restarts at digit 0.
- Macro defined, din=32'h0000_0012 -> digit0=A4, digit1=F9, digits 2..7 seg=FF; din=0 -> only digit 0 shows C0.
